// File: rtl/crc32_dec_arbiter.sv
// Round-robin sharing of one CRC32 check unit among NUM_REQ requesters, tagged responses out.
// Optional per-requester mismatch counters when CRC32_DEC_ARB_ERR_CNT_EN is defined.

// Generic FIFO: single-clock, power-of-two depth, registered head.
// Latency: push visible at the head the cycle after it is written.
// Backpressure: push is taken only when not full or when a pop happens in the same cycle.
module crc32_dec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Arbiter in front of a 1-cycle CRC32 check unit; results queued in a response FIFO.
// Latency: accept at T, response valid at T+2 at the earliest; one per cycle sustained.
// Backpressure: rsp_ready_i low fills the FIFO; credits then hold every req_ready_o low.
module crc32_dec_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ*CRC_WIDTH-1:0]    req_checksum_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            dec_valid_o,
  output logic [DATA_WIDTH-1:0]           dec_data_o,
  output logic [CRC_WIDTH-1:0]            dec_checksum_o,
  input  logic                            dec_valid_i,
  input  logic                            dec_detected_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic                            rsp_detected_o,
  output logic                            proto_err_o
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
  ,
  input  logic                            err_cnt_clr_i,
  output logic [NUM_REQ*16-1:0]           err_cnt_o
`endif
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 2;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] dat;
    logic                  det;
  } rsp_t;

  logic [ID_W-1:0]       rr_ptr, gnt_id, nxt_ptr;
  logic [ID_W:0]         sum;
  logic                  gnt_vld, issue, credit_ok, pop;
  logic                  inflight_q;
  logic [ID_W-1:0]       infl_id;
  logic [DATA_WIDTH-1:0] infl_dat;
  logic [FAW:0]          fifo_cnt;
  logic                  fifo_empty;
  logic [CW-1:0]         used;
  rsp_t                  push_ent, head_ent;

  assign pop       = rsp_valid_o & rsp_ready_i;
  // A same-cycle pop frees a slot in time for this cycle's issue.
  assign used      = CW'(fifo_cnt) + CW'(inflight_q);
  assign credit_ok = used < (CW'(FIFO_DEPTH) + CW'(pop));

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!gnt_vld && req_valid_i[sum[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = sum[ID_W-1:0];
      end
    end
  end

  assign issue          = gnt_vld & credit_ok & rst_n;
  assign req_ready_o    = issue ? (NUM_REQ'(1) << gnt_id) : '0;
  assign dec_valid_o    = issue;
  assign dec_data_o     = req_data_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
  assign dec_checksum_o = req_checksum_i[gnt_id*CRC_WIDTH +: CRC_WIDTH];
  assign nxt_ptr        = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      inflight_q  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      // Every outstanding issue resolves next cycle, returned or dropped.
      inflight_q <= issue;
      if (issue) rr_ptr <= nxt_ptr;
      if (dec_valid_i != inflight_q) proto_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      infl_id  <= gnt_id;
      infl_dat <= dec_data_o;
    end
  end

  assign push_ent = '{id: infl_id, dat: infl_dat, det: dec_detected_i};

  crc32_dec_fifo #(.W($bits(rsp_t)), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (dec_valid_i & inflight_q),
    .push_dat (push_ent),
    .pop      (rsp_ready_i),
    .pop_dat  (head_ent),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign rsp_valid_o    = ~fifo_empty;
  assign rsp_id_o       = head_ent.id;
  assign rsp_data_o     = head_ent.dat;
  assign rsp_detected_o = head_ent.det;

`ifdef CRC32_DEC_ARB_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || err_cnt_clr_i) begin
      err_cnt_o <= '0;
    end else if (pop && rsp_detected_o) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_id_o == ID_W'(i) && err_cnt_o[i*16 +: 16] != 16'hFFFF)
          err_cnt_o[i*16 +: 16] <= err_cnt_o[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_crc32_dec_arbiter.sv
// Randomized bench for crc32_dec_arbiter with a behavioural CRC32 check unit and scoreboard.
module tb_crc32_dec_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 512;
  localparam int CW      = 32;
  localparam int DEPTH   = 2;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ*DW-1:0]   req_data_i;
  logic [NUM_REQ*CW-1:0]   req_checksum_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic                    dec_valid_o;
  logic [DW-1:0]           dec_data_o;
  logic [CW-1:0]           dec_checksum_o;
  logic                    dec_valid_i, dec_detected_i;
  logic                    rsp_valid_o, rsp_ready_i;
  logic [ID_W-1:0]         rsp_id_o;
  logic [DW-1:0]           rsp_data_o;
  logic                    rsp_detected_o, proto_err_o;
  logic                    dec_vq, dec_dq, spur;
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
  logic                    err_cnt_clr_i = 1'b0;
  logic [NUM_REQ*16-1:0]   err_cnt_o;
  int                      ecnt [NUM_REQ];
`endif

  always #5 clk = ~clk;

  crc32_dec_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .CRC_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_checksum_i (req_checksum_i),
    .req_ready_o    (req_ready_o),
    .dec_valid_o    (dec_valid_o),
    .dec_data_o     (dec_data_o),
    .dec_checksum_o (dec_checksum_o),
    .dec_valid_i    (dec_valid_i),
    .dec_detected_i (dec_detected_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_id_o       (rsp_id_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_detected_o (rsp_detected_o),
    .proto_err_o    (proto_err_o)
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
    ,
    .err_cnt_clr_i  (err_cnt_clr_i),
    .err_cnt_o      (err_cnt_o)
`endif
  );

  function automatic logic [CW-1:0] crc32(input logic [DW-1:0] d);
    logic [31:0] c;
    logic        b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < DW; i++) begin
      b = c[0] ^ d[i];
      c = c >> 1;
      if (b) c = c ^ 32'hEDB8_8320;
    end
    return ~c;
  endfunction

  // Behavioural check unit: one cycle from dec_valid_o to dec_valid_i.
  always @(posedge clk) begin
    if (!rst_n) begin
      dec_vq <= 1'b0;
      dec_dq <= 1'b0;
    end else begin
      dec_vq <= dec_valid_o;
      dec_dq <= (crc32(dec_data_o) != dec_checksum_o);
    end
  end
  assign dec_valid_i    = dec_vq | spur;
  assign dec_detected_i = dec_dq;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chk;
    logic          bad;
  } item_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          bad;
    int            cyc;
  } exp_t;

  item_t pend [NUM_REQ][$];
  exp_t  exp_q[$];
  int    ptr, cyc, exp_proto;
  int    n_chk, n_pass;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic new_item(input int r, input bit bad);
    item_t it;
    for (int w = 0; w < DW/32; w++) it.data[w*32 +: 32] = $urandom;
    it.chk = crc32(it.data) ^ {31'b0, bad};
    it.bad = bad;
    pend[r].push_back(it);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int r = 0; r < NUM_REQ; r++) pend[r].delete();
    ptr       = 0;
    exp_proto = 0;
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
    for (int r = 0; r < NUM_REQ; r++) ecnt[r] = 0;
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n       = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    spur        = 1'b0;
    #1;
    check("rst_req_ready", req_ready_o, 0);
    check("rst_dec_valid", dec_valid_o, 0);
    clear_model();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input int p_ready, input bit spurious);
    bit   exp_rv, pop, allow;
    int   gnt, outst;
    exp_t e;
    @(negedge clk);
    rsp_ready_i = ($urandom_range(99) < p_ready);
    spur        = spurious;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_valid_i[r] = (pend[r].size() > 0);
      req_data_i[r*DW +: DW]     = req_valid_i[r] ? pend[r][0].data : '0;
      req_checksum_i[r*CW +: CW] = req_valid_i[r] ? pend[r][0].chk  : '0;
    end
    #1;
    exp_rv = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
    pop    = exp_rv && rsp_ready_i;
    outst  = exp_q.size();
    allow  = (outst - (pop ? 1 : 0)) < DEPTH;
    gnt    = -1;
    if (allow) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx = (ptr + k) % NUM_REQ;
        if (gnt < 0 && pend[idx].size() > 0) gnt = idx;
      end
    end
    check("req_ready", req_ready_o, (gnt >= 0) ? (1 << gnt) : 0);
    check("dec_valid", dec_valid_o, gnt >= 0);
    if (gnt >= 0) begin
      check("dec_data", dec_data_o, pend[gnt][0].data);
      check("dec_checksum", dec_checksum_o, pend[gnt][0].chk);
    end
    check("rsp_valid", rsp_valid_o, exp_rv);
    if (exp_rv) begin
      check("rsp_id", rsp_id_o, exp_q[0].id);
      check("rsp_data", rsp_data_o, exp_q[0].data);
      check("rsp_detected", rsp_detected_o, exp_q[0].bad);
    end
    check("proto_err", proto_err_o, exp_proto);
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
    for (int r = 0; r < NUM_REQ; r++) check("err_cnt", err_cnt_o[r*16 +: 16], ecnt[r]);
`endif
    if (pop) begin
      e = exp_q.pop_front();
`ifdef CRC32_DEC_ARB_ERR_CNT_EN
      if (e.bad && ecnt[e.id] < 65535) ecnt[e.id]++;
`endif
    end
    if (gnt >= 0) begin
      e.id   = gnt;
      e.data = pend[gnt][0].data;
      e.bad  = pend[gnt][0].bad;
      e.cyc  = cyc;
      exp_q.push_back(e);
      void'(pend[gnt].pop_front());
      ptr = (gnt + 1) % NUM_REQ;
    end
    if (spurious) exp_proto = 1;
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b0; spur = 1'b0; rsp_ready_i = 1'b0;
    req_valid_i = '0; req_data_i = '0; req_checksum_i = '0;
    do_reset(2);
    repeat (2) step(100, 0);

    // Lone requester 2 with a good checksum.
    new_item(2, 1'b0);
    repeat (5) step(100, 0);

    // All four requesters busy: rotating grants, no bubbles.
    for (int r = 0; r < NUM_REQ; r++) repeat (4) new_item(r, 1'b0);
    repeat (20) step(100, 0);

    // Corrupted checksum from requester 1.
    new_item(1, 1'b1);
    repeat (5) step(100, 0);

    // Response stall: credits cap acceptance at the FIFO depth, then resume.
    for (int r = 0; r < NUM_REQ; r++) repeat (3) new_item(r, 1'b0);
    repeat (6) step(0, 0);
    repeat (20) step(100, 0);

    // Spurious return with one entry queued and nothing outstanding.
    new_item(0, 1'b0);
    repeat (4) step(0, 0);
    step(0, 1);
    repeat (2) step(0, 0);
    repeat (4) step(100, 0);

    // Reset with one entry queued and one outstanding.
    new_item(0, 1'b0);
    new_item(1, 1'b0);
    step(0, 0);
    step(0, 0);
    do_reset(1);
    new_item(3, 1'b0);
    repeat (5) step(100, 0);

    // Random traffic and random backpressure.
    repeat (400) begin
      for (int r = 0; r < NUM_REQ; r++)
        if ($urandom_range(99) < 30 && pend[r].size() < 3) new_item(r, $urandom_range(7) == 0);
      step(60, 0);
    end
    repeat (30) step(100, 0);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/crc32_dec_arbiter.md
Name: crc32_dec_arbiter

Overview:
- Shares one 1-cycle-latency CRC32 decoder instance among NUM_REQ requesters.
- Round-robin arbitration; per-requester valid/ready handshake on the request side.
- The decoder has no backpressure, so issue is gated by credits against an internal response FIFO.
- The returned detected flag is tagged with the requester ID and its data, then presented on a single valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 512, payload width.
- CRC_WIDTH, 32, checksum width.
- FIFO_DEPTH, 2, response FIFO entries (power of two, >=2).
- ID_W, $clog2(NUM_REQ), requester ID width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester payload; slice i belongs to requester i.
- req_checksum_i  in  NUM_REQ*CRC_WIDTH  per-requester received checksum.
- req_ready_o  out  NUM_REQ  one-hot grant/accept.
- dec_valid_o  out  1  decoder valid_i.
- dec_data_o  out  DATA_WIDTH  decoder data_i.
- dec_checksum_o  out  CRC_WIDTH  decoder checksum_i.
- dec_valid_i  in  1  decoder valid_o.
- dec_detected_i  in  1  decoder detected_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_id_o  out  ID_W  requester index of the response.
- rsp_data_o  out  DATA_WIDTH  payload of the response.
- rsp_detected_o  out  1  1 = CRC mismatch.
- proto_err_o  out  1  sticky protocol error.

Behaviour:
- Clock/reset: rst_n is synchronous and active-low; clk is the clock.
- Reset values:
  - req_ready_o=0, dec_valid_o=0, rsp_valid_o=0, proto_err_o=0.
  - FIFO empty, in-flight flag clear.
  - RR pointer=0, so requester 0 has highest priority.
  - Data outputs are don't-care while their valid is 0.
- Credit rule: issue allowed in cycle T iff (fifo_count + inflight - pop_T) < FIFO_DEPTH. pop_T = rsp_valid_o & rsp_ready_i.
- Arbitration (combinational):
  - If the credit rule holds, grant the first requester with req_valid_i=1, searching from the RR pointer upward with wrap.
  - req_ready_o is one-hot on the grant, else 0.
  - req_ready_o never asserts for a requester whose valid is low.
- Issue (cycle T): dec_valid_o=1, with dec_data_o/dec_checksum_o = the granted slices, combinationally in T.
- Capture at the T edge:
  - in-flight register <= {id, data}; inflight <= 1.
  - RR pointer <= grant+1 (mod NUM_REQ).
  - With no grant, the pointer holds.
- Return (cycle T+1):
  - Expect dec_valid_i=1.
  - Push {in-flight id, in-flight data, dec_detected_i} into the FIFO.
  - inflight clears unless a new issue occurs in the same cycle; back-to-back issue every cycle is allowed.
  - The decoder's data output is not used; payload comes from the in-flight register.
- Latency: accept at T -> rsp_valid_o earliest at T+2.
- Throughput: 1 per cycle while rsp_ready_i=1.
- Response port:
  - FIFO head drives rsp_*.
  - rsp_* stays stable while rsp_valid_o & !rsp_ready_i.
  - Push and pop in the same cycle are permitted at any occupancy, including full with a pop.
- Protocol error:
  - dec_valid_i=1 with inflight=0, or dec_valid_i=0 with inflight=1, sets proto_err_o=1 (sticky until reset).
  - On dec_valid_i=0 with inflight=1, the in-flight entry is dropped and its credit is released.
- Reset mid-operation: in-flight and FIFO contents are discarded; the next request after reset is arbitrated from pointer 0.

Optional Feature:
- Macro: CRC32_DEC_ARB_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt_o [NUM_REQ*16-1:0], one 16-bit saturating counter per requester.
  - A counter increments when a response with rsp_detected_o=1 is popped for that ID.
  - Counters hold at 16'hFFFF and reset to 0.
  - Adds input err_cnt_clr_i (1 bit): clears all counters the next cycle; clear wins over a simultaneous increment.
- When undefined: no port, no counter logic.

Test Plan:
- Single request: req 2 valid, good checksum, rsp_ready_i=1 -> req_ready_o=4'b0100 at T; rsp_valid_o at T+2 with id=2, data matching, detected=0.
- All four valid continuously, rsp_ready_i=1 -> grants 0,1,2,3,0,... one per cycle; responses in the same order, no bubbles.
- Bad checksum (bit 0 flipped) from req 1 -> rsp_detected_o=1, id=1. With CRC32_DEC_ARB_ERR_CNT_EN defined, err_cnt_o slice 1 becomes 1 after the pop.
- rsp_ready_i=0, FIFO_DEPTH=2, all requesting -> exactly 2 requests accepted, then req_ready_o=0. Raise rsp_ready_i -> issue resumes in the same cycle as the first pop; no loss, no duplication.
- Spurious dec_valid_i=1 with nothing in flight -> proto_err_o=1 next cycle and stays set; FIFO count unchanged.
- rst_n low for 1 cycle with 1 in flight and 1 queued -> all outputs at reset values; next request from req 3 (pointer 0, only req 3 valid) granted and returned with id=3.
